// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and helpers for the execute/memory pipeline register.
//   Widths: REG_W (general register / HI/LO), REG_ADDR_W (register-file address),
//           STALL_W (central stall vector), CNT_W (accumulate cycle count).
//   Stall indices: STALL_EX (execute stalled), STALL_MEM (memory stalled).
//   decode_action(): resolves rst/flush/stall into the per-edge register action.
package ex_mem_reg_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned CNT_W      = 2;

    localparam int unsigned STALL_EX   = 3;
    localparam int unsigned STALL_MEM  = 4;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [REG_W-1:0]      ZERO_WORD = '0;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = '0;

    // What the register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,  // execute and memory both stalled
        ACT_ADVANCE = 2'd1,  // execute result moves to memory
        ACT_BUBBLE  = 2'd2,  // execute stalled, memory free: send a nop
        ACT_CLEAR   = 2'd3   // reset or flush
    } action_e;

    // Priority: rst, flush, bubble, advance, hold.
    function automatic action_e decode_action(
        input logic rst,
        input logic flush,
        input logic ex_stall,
        input logic mem_stall
    );
        if (rst == RST_ENABLE) begin
            return ACT_CLEAR;
        end
        if (flush) begin
            return ACT_CLEAR;
        end
        if (ex_stall && !mem_stall) begin
            return ACT_BUBBLE;
        end
        if (!ex_stall) begin
            return ACT_ADVANCE;
        end
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: pipeline register between the execute and memory stages.
//   Captures the register-file and HI/LO write request from execute each edge and
//   presents it to the memory stage one cycle later. Honours the stall vector and
//   flush, inserting nops where execute stalls but memory does not.
//   Also returns the partial 64-bit product and cycle count of multi-cycle
//   multiply-accumulate instructions back to execute.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   stall[5:0]  bit 3 execute stalled, bit 4 memory stalled, others ignored
//   flush       discard in-flight instruction
//   ex_wd/ex_wreg/ex_wdata, ex_whilo/ex_hi/ex_lo  -> mem_* (registered)
//   hilo_i/cnt_i -> hilo_o/cnt_o (registered accumulate feedback)
//
// Configuration macro EX_MEM_MADD_EN:
//   defined   - accumulate feedback registers present
//   undefined - hilo_o/cnt_o tied to zero, hilo_i/cnt_i ignored
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned DATA_W = REG_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      cnt_o
);

    action_e action;

    // Resolve the per-edge action from the control inputs.
    always_comb begin
        action = decode_action(rst, flush, stall[STALL_EX], stall[STALL_MEM]);
    end

    // Only the execute and memory stall bits matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Write request towards the memory stage.
    always_ff @(posedge clk) begin
        unique case (action)
            ACT_CLEAR, ACT_BUBBLE: begin
                mem_wd    <= ADDR_W'(REG_ZERO);
                mem_wreg  <= WRITE_DISABLE;
                mem_wdata <= DATA_W'(ZERO_WORD);
                mem_whilo <= WRITE_DISABLE;
                mem_hi    <= DATA_W'(ZERO_WORD);
                mem_lo    <= DATA_W'(ZERO_WORD);
            end
            ACT_ADVANCE: begin
                mem_wd    <= ex_wd;
                mem_wreg  <= ex_wreg;
                mem_wdata <= ex_wdata;
                mem_whilo <= ex_whilo;
                mem_hi    <= ex_hi;
                mem_lo    <= ex_lo;
            end
            ACT_HOLD: begin
            end
        endcase
    end

`ifdef EX_MEM_MADD_EN
    // Accumulate feedback: only progresses while execute is stalled; any
    // advance or clear means the accumulate has finished or been aborted.
    always_ff @(posedge clk) begin
        unique case (action)
            ACT_CLEAR, ACT_ADVANCE: begin
                hilo_o <= '0;
                cnt_o  <= '0;
            end
            ACT_BUBBLE: begin
                hilo_o <= hilo_i;
                cnt_o  <= cnt_i;
            end
            ACT_HOLD: begin
            end
        endcase
    end
`else
    assign hilo_o = '0;
    assign cnt_o  = '0;

    logic unused_madd;
    assign unused_madd = ^{hilo_i, cnt_i};
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, hand-written
// accumulate/combinational-path sequences, and randomized traffic against a
// behavioural model of the stage-register rules.
module tb_ex_mem_reg;

`ifdef EX_MEM_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } in_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input out_t e);
        check({tag, ".mem_wd"},    64'(mem_wd),    64'(e.wd));
        check({tag, ".mem_wreg"},  64'(mem_wreg),  64'(e.wreg));
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
        check({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(e.whilo));
        check({tag, ".mem_hi"},    64'(mem_hi),    64'(e.hi));
        check({tag, ".mem_lo"},    64'(mem_lo),    64'(e.lo));
        check({tag, ".hilo_o"},    hilo_o,         MADD_EN ? e.hilo : 64'h0);
        check({tag, ".cnt_o"},     64'(cnt_o),     MADD_EN ? 64'(e.cnt) : 64'h0);
    endtask

    task automatic drive(input in_t v);
        rst      = v.rst;
        flush    = v.flush;
        stall    = v.stall;
        ex_wd    = v.wd;
        ex_wreg  = v.wreg;
        ex_wdata = v.wdata;
        ex_whilo = v.whilo;
        ex_hi    = v.hi;
        ex_lo    = v.lo;
        hilo_i   = v.hilo;
        cnt_i    = v.cnt;
    endtask

    // Behavioural model: what the stage presents after one edge.
    function automatic out_t model_step(input out_t cur, input in_t v);
        out_t n;
        n = '{default: '0};
        if (v.rst || v.flush) begin
            return n;
        end
        if (!v.stall[3]) begin
            n.wd = v.wd; n.wreg = v.wreg; n.wdata = v.wdata;
            n.whilo = v.whilo; n.hi = v.hi; n.lo = v.lo;
            return n;
        end
        if (!v.stall[4]) begin
            n.hilo = MADD_EN ? v.hilo : 64'h0;
            n.cnt  = MADD_EN ? v.cnt : 2'd0;
            return n;
        end
        return cur;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.rst   = ($urandom_range(0, 31) == 0);
        v.flush = ($urandom_range(0, 15) == 0);
        v.stall = 6'($urandom);
        v.wd    = 5'($urandom);
        v.wreg  = 1'($urandom);
        v.wdata = $urandom;
        v.whilo = 1'($urandom);
        v.hi    = $urandom;
        v.lo    = $urandom;
        v.hilo  = {$urandom, $urandom};
        v.cnt   = 2'($urandom);
        return v;
    endfunction

    vec_t tbl [18];
    out_t mdl;
    out_t exp_o;
    in_t  v;

    initial begin
        // {rst,flush,stall,wd,wreg,wdata,whilo,hi,lo,hilo_i,cnt_i} -> {wd,wreg,wdata,whilo,hi,lo,hilo_o,cnt_o}
        tbl[0]  = '{'{1,0,6'h00, 7,1,32'hDEAD_BEEF,0,0,0,64'h0,0}, '{0,0,0,0,0,0,64'h0,0}};
        tbl[1]  = '{'{1,0,6'h00, 7,1,32'hDEAD_BEEF,0,0,0,64'h0,0}, '{0,0,0,0,0,0,64'h0,0}};
        tbl[2]  = '{'{0,0,6'h00, 7,1,32'hDEAD_BEEF,0,0,0,64'h0,0}, '{7,1,32'hDEAD_BEEF,0,0,0,64'h0,0}};
        tbl[3]  = '{'{0,0,6'h00, 0,0,0,1,1,2,64'h0,0}, '{0,0,0,1,1,2,64'h0,0}};
        tbl[4]  = '{'{0,0,6'b001000, 3,1,32'h55,1,7,8,64'h0000_0001_0000_0002,1},
                    '{0,0,0,0,0,0,64'h0000_0001_0000_0002,1}};
        tbl[5]  = '{'{0,0,6'h00, 4,1,32'h1234,0,0,0,64'h99,2}, '{4,1,32'h1234,0,0,0,64'h0,0}};
        tbl[6]  = '{'{0,0,6'b011000, 9,0,32'hAAAA,1,3,4,64'h5,1}, '{4,1,32'h1234,0,0,0,64'h0,0}};
        tbl[7]  = '{'{0,0,6'b011000, 10,1,32'hBBBB,1,5,6,64'h6,2}, '{4,1,32'h1234,0,0,0,64'h0,0}};
        tbl[8]  = '{'{0,0,6'b011000, 11,1,32'hCCCC,0,7,8,64'h7,3}, '{4,1,32'h1234,0,0,0,64'h0,0}};
        tbl[9]  = '{'{0,0,6'b001000, 12,1,32'hDDDD,1,5,6,64'h1122_3344_5566_7788,1},
                    '{0,0,0,0,0,0,64'h1122_3344_5566_7788,1}};
        tbl[10] = '{'{0,0,6'b011000, 13,1,32'hEEEE,1,9,9,64'hF,2},
                    '{0,0,0,0,0,0,64'h1122_3344_5566_7788,1}};
        tbl[11] = '{'{0,1,6'b011000, 14,1,32'h7777,1,1,1,64'h3,3}, '{0,0,0,0,0,0,64'h0,0}};
        tbl[12] = '{'{0,0,6'b001000, 15,1,32'h8888,0,0,0,64'hFFFF_FFFF_FFFF_FFFF,2},
                    '{0,0,0,0,0,0,64'hFFFF_FFFF_FFFF_FFFF,2}};
        tbl[13] = '{'{0,1,6'h00, 16,1,32'h9999,1,2,3,64'h4,1}, '{0,0,0,0,0,0,64'h0,0}};
        tbl[14] = '{'{0,0,6'b100111, 31,1,32'hFFFF_FFFF,1,32'hA,32'hB,64'h8,3},
                    '{31,1,32'hFFFF_FFFF,1,32'hA,32'hB,64'h0,0}};
        tbl[15] = '{'{0,0,6'b010000, 1,0,32'h1,0,32'h2,32'h3,64'h9,1}, '{1,0,32'h1,0,32'h2,32'h3,64'h0,0}};
        tbl[16] = '{'{0,0,6'b101001, 2,1,32'h42,1,4,5,64'hABCD,3}, '{0,0,0,0,0,0,64'hABCD,3}};
        tbl[17] = '{'{1,1,6'b011000, 3,1,32'h43,1,6,7,64'hEF,2}, '{0,0,0,0,0,0,64'h0,0}};

        v = '{default: '0};
        v.rst = 1'b1;
        drive(v);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].i);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].e);
        end
        mdl = '{default: '0};

        // Accumulate: stall with partial product, then consume and advance.
        @(negedge clk);
        v = '{default: '0};
        v.stall = 6'b001000; v.wreg = 1'b1; v.wd = 5'd6;
        v.hilo = 64'h0000_00AA_0000_00BB; v.cnt = 2'd1;
        drive(v);
        @(posedge clk); #1;
        exp_o = '{default: '0};
        exp_o.hilo = 64'h0000_00AA_0000_00BB; exp_o.cnt = 2'd1;
        check_out("madd1", exp_o);
        @(negedge clk);
        v.stall = 6'h00; v.wdata = 32'h0BAD_F00D; v.cnt = 2'd2; v.hilo = 64'h1;
        drive(v);
        @(posedge clk); #1;
        exp_o = '{default: '0};
        exp_o.wd = 5'd6; exp_o.wreg = 1'b1; exp_o.wdata = 32'h0BAD_F00D;
        check_out("madd2", exp_o);

        // Inputs changing mid-cycle must not reach the outputs before an edge.
        @(negedge clk);
        v.wdata = 32'h5A5A_5A5A; v.wd = 5'd17;
        drive(v);
        #2;
        check("comb_path.mem_wdata", 64'(mem_wdata), 64'h0BAD_F00D);
        check("comb_path.mem_wd", 64'(mem_wd), 64'd6);
        @(posedge clk); #1;
        check("comb_path_edge.mem_wdata", 64'(mem_wdata), 64'h5A5A_5A5A);
        mdl = exp_o;
        mdl.wd = 5'd17; mdl.wdata = 32'h5A5A_5A5A;

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            v = rand_in();
            drive(v);
            mdl = model_step(mdl, v);
            @(posedge clk); #1;
            check_out($sformatf("rand%0d", c), mdl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute stage and the memory stage of the five-stage MIPS core. Captures the execute stage's register-file write request and HI/LO write request on each clock and presents them to the memory stage for the next cycle. Honours the central stall vector and a flush, inserting bubbles where required. Also carries the intermediate 64-bit product and cycle count that multi-cycle multiply-accumulate instructions (madd/maddu/msub/msubu) feed back into execute.

## Interface
Parameters:
- DATA_W, 32, general-register and HI/LO width
- ADDR_W, 5, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  stall vector; bit 3 = execute stalled, bit 4 = memory stalled
- flush  in  1  discard in-flight instruction
- ex_wd  in  ADDR_W  destination register address
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  register write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi  in  DATA_W  HI write data
- ex_lo  in  DATA_W  LO write data
- hilo_i  in  2*DATA_W  intermediate accumulate product from execute
- cnt_i  in  2  accumulate cycle count from execute
- mem_wd  out  ADDR_W  registered ex_wd
- mem_wreg  out  1  registered ex_wreg
- mem_wdata  out  DATA_W  registered ex_wdata
- mem_whilo  out  1  registered ex_whilo
- mem_hi  out  DATA_W  registered ex_hi
- mem_lo  out  DATA_W  registered ex_lo
- hilo_o  out  2*DATA_W  intermediate product returned to execute
- cnt_o  out  2  cycle count returned to execute

## Operation
- All outputs are flops; no combinational path from any input to any output.
- Priority per rising edge, highest first: rst, flush, bubble, advance, hold.
- rst: every output cleared to zero (addresses zero, enables disabled, data zero, hilo_o zero, cnt_o zero).
- flush (rst low): mem_* outputs cleared to zero; hilo_o and cnt_o cleared to zero (aborted accumulate restarts).
- Bubble: stall[3]=1 and stall[4]=0 -> mem_* outputs cleared to zero (nop to memory stage); hilo_o <= hilo_i, cnt_o <= cnt_i (accumulate progresses).
- Advance: stall[3]=0 -> mem_* <= ex_*; hilo_o and cnt_o cleared to zero.
- Hold: stall[3]=1 and stall[4]=1 -> all outputs retain value.
- Other stall bits ignored.
- No arithmetic; widths pass through unchanged.

## Timing
- Latency one cycle: values on ex_* at edge N appear on mem_* after edge N.
- Reset observed only at clock edge; outputs stay zero while rst high.
- flush simultaneous with any stall pattern: flush wins.
- Accumulate sequence: cycle 1 execute stalls with cnt_i=1 and partial product on hilo_i; after that edge cnt_o=1, hilo_o valid; cycle 2 execute consumes hilo_o/cnt_o, deasserts stall[3], final result advances and hilo_o/cnt_o return to zero.

## Configuration
- Macro EX_MEM_MADD_EN.
- Defined: hilo_i/cnt_i/hilo_o/cnt_o feedback behaves as above.
- Undefined: hilo_o and cnt_o tied to zero, no flops for them; ports remain so the interface is unchanged; hilo_i/cnt_i ignored.

## Structure
- Shared package/define file: Rst_Enable, Write_Enable/Write_Disable, Zero_Word, Reg_Zero, Reg/Reg_Addr widths, stall-bit index constants (STALL_EX=3, STALL_MEM=4).
- No sub-module; single flat register block.

## Test plan
- rst=1 for 2 cycles with ex_wd=5'd7, ex_wreg=1, ex_wdata=32'hDEAD_BEEF -> all outputs zero; after release, next edge mem_wd=7, mem_wreg=1, mem_wdata=32'hDEAD_BEEF.
- Advance: ex_whilo=1, ex_hi=32'h1, ex_lo=32'h2, stall=0 -> one cycle later mem_whilo=1, mem_hi=1, mem_lo=2.
- Bubble: stall=6'b001000, ex_wreg=1, hilo_i=64'h0000_0001_0000_0002, cnt_i=1 -> mem_wreg=0, mem_wdata=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=1.
- Hold: load mem_wdata=32'h1234, then stall=6'b011000 for 3 cycles with changing ex_* -> mem_wdata stays 32'h1234.
- Flush with stall=6'b011000 and prior cnt_o=1 -> all outputs zero next cycle.
- With EX_MEM_MADD_EN undefined, bubble with hilo_i=64'hFFFF_FFFF_FFFF_FFFF, cnt_i=2 -> hilo_o=0, cnt_o=0.
